// File: rtl/cache_level_ctrl.sv
// cache_level_ctrl: parametrised set-associative cache level
// with write-back, miss/fill FSM and push/pop next-level link.
module cache_level_ctrl #(
  parameter int ADDR_W     = 24,
  parameter int LINE_BYTES = 8,
  parameter int SETS       = 8,
  parameter int WAYS       = 4
) (
  input  logic                           CLK,
  input  logic                           Reset,
  input  logic                           Req_Valid,
  output logic                           Req_Ready,
  input  logic                           Req_Write,
  input  logic [ADDR_W-1:0]              Req_Addr,
  input  logic [7:0]                     Req_WData,
  output logic                           Resp_Valid,
  output logic [7:0]                     Resp_Data,
  output logic                           Resp_Hit,
  output logic                           Push_Valid,
  input  logic                           Push_Ready,
  output logic [ADDR_W+8*LINE_BYTES:0]   Push_Msg,
  input  logic                           Pop_Valid,
  output logic                           Pop_Ready,
  input  logic [ADDR_W+8*LINE_BYTES-1:0] Pop_Data,
  output logic                           Evict,
  output logic                           Busy
);

  localparam int DATA_W = 8 * LINE_BYTES;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LA_W   = ADDR_W - OFF_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB, FILLREQ, FILLWAIT, COMMIT, RESP
  } state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];

  logic              req_write_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [7:0]        req_wdata_q;
  logic [WAY_W-1:0]  vic_q;
  logic [DATA_W-1:0] fill_q;
  logic              resp_hit_q;
  logic [7:0]        resp_data_q;
  logic              push_valid_q;
  logic [ADDR_W+DATA_W:0] push_msg_q;
  logic              evict_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [OFF_W-1:0]  off;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_f, cln_f;
  logic [WAY_W-1:0]  inv_w, cln_w;
  logic              use_rr;
  logic [WAY_W-1:0]  vic;
  logic [DATA_W-1:0] hit_line;
  logic              pop_hit;
  logic              push_fire;
  logic              pop_off_unused;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] line,
    input logic [OFF_W-1:0]  o,
    input logic [7:0]        b
  );
    logic [DATA_W-1:0] r;
    r = line;
    r[{o, 3'b000} +: 8] = b;
    return r;
  endfunction

  assign idx = req_addr_q[OFF_W +: IDX_W];
  assign tag = req_addr_q[ADDR_W-1 -: TAG_W];
  assign off = req_addr_q[OFF_W-1:0];

  assign pop_hit = Pop_Valid &&
    (Pop_Data[ADDR_W+DATA_W-1 -: LA_W] == req_addr_q[ADDR_W-1 -: LA_W]);
  assign pop_off_unused = ^Pop_Data[DATA_W +: OFF_W];
  assign push_fire = push_valid_q && Push_Ready;

  assign Req_Ready  = (state_q == IDLE);
  assign Busy       = (state_q != IDLE);
  assign Pop_Ready  = (state_q == FILLWAIT);
  assign Resp_Valid = (state_q == RESP);
  assign Resp_Data  = resp_data_q;
  assign Resp_Hit   = resp_hit_q;
  assign Push_Valid = push_valid_q;
  assign Push_Msg   = push_msg_q;
  assign Evict      = evict_q;

  // Tag match and victim choice: invalid, then clean, then round-robin.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    inv_f   = 1'b0;
    inv_w   = '0;
    cln_f   = 1'b0;
    cln_w   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_f = 1'b1;
        inv_w = WAY_W'(w);
      end else if (!dirty_q[idx][w]) begin
        cln_f = 1'b1;
        cln_w = WAY_W'(w);
      end
    end
    use_rr   = !inv_f && !cln_f;
    vic      = inv_f ? inv_w : (cln_f ? cln_w : rr_q[idx]);
    hit_line = data_q[idx][hit_way];
  end

  // State register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (Req_Valid) state_d = LOOKUP;
      LOOKUP:   state_d = hit ? RESP : (use_rr ? WB : FILLREQ);
      WB:       if (push_fire) state_d = FILLREQ;
      FILLREQ:  if (push_fire) state_d = FILLWAIT;
      FILLWAIT: if (pop_hit) state_d = COMMIT;
      COMMIT:   state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Storage, request latch, push channel and response registers.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
        end
      end
      req_write_q  <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      vic_q        <= '0;
      fill_q       <= '0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
      push_valid_q <= 1'b0;
      push_msg_q   <= '0;
      evict_q      <= 1'b0;
    end else begin
      evict_q <= 1'b0;
      case (state_q)
        IDLE: if (Req_Valid) begin
          req_write_q <= Req_Write;
          req_addr_q  <= Req_Addr;
          req_wdata_q <= Req_WData;
        end
        LOOKUP: if (hit) begin
          resp_hit_q <= 1'b1;
          if (req_write_q) begin
            data_q[idx][hit_way]  <= merge(hit_line, off, req_wdata_q);
            dirty_q[idx][hit_way] <= 1'b1;
            resp_data_q           <= req_wdata_q;
          end else begin
            resp_data_q <= hit_line[{off, 3'b000} +: 8];
          end
        end else begin
          vic_q        <= vic;
          push_valid_q <= 1'b1;
          if (use_rr) begin
            rr_q[idx]  <= rr_q[idx] + 1'b1;
            evict_q    <= 1'b1;
            push_msg_q <= {1'b1, tag_q[idx][vic], idx,
                           {OFF_W{1'b0}}, data_q[idx][vic]};
          end else begin
            push_msg_q <= {1'b0, req_addr_q[ADDR_W-1 -: LA_W],
                           {OFF_W{1'b0}}, {DATA_W{1'b0}}};
          end
        end
        WB: if (push_fire) begin
          push_msg_q <= {1'b0, req_addr_q[ADDR_W-1 -: LA_W],
                         {OFF_W{1'b0}}, {DATA_W{1'b0}}};
        end
        FILLREQ: if (push_fire) push_valid_q <= 1'b0;
        FILLWAIT: if (pop_hit) fill_q <= Pop_Data[DATA_W-1:0];
        COMMIT: begin
          tag_q[idx][vic_q]   <= tag;
          valid_q[idx][vic_q] <= 1'b1;
          dirty_q[idx][vic_q] <= req_write_q;
          data_q[idx][vic_q]  <= req_write_q ?
            merge(fill_q, off, req_wdata_q) : fill_q;
          resp_hit_q  <= 1'b0;
          resp_data_q <= req_write_q ? req_wdata_q
                                     : fill_q[{off, 3'b000} +: 8];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_level_ctrl.sv
// tb_cache_level_ctrl: directed bench for cache_level_ctrl
// (default parameters, hand-computed expectations).
module tb_cache_level_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Req_Valid;
  logic        Req_Ready;
  logic        Req_Write;
  logic [23:0] Req_Addr;
  logic [7:0]  Req_WData;
  logic        Resp_Valid;
  logic [7:0]  Resp_Data;
  logic        Resp_Hit;
  logic        Push_Valid;
  logic        Push_Ready;
  logic [88:0] Push_Msg;
  logic        Pop_Valid;
  logic        Pop_Ready;
  logic [87:0] Pop_Data;
  logic        Evict;
  logic        Busy;

  int tests = 0;
  int fails = 0;

  cache_level_ctrl dut (
    .CLK(CLK), .Reset(Reset),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_Write(Req_Write), .Req_Addr(Req_Addr),
    .Req_WData(Req_WData),
    .Resp_Valid(Resp_Valid), .Resp_Data(Resp_Data),
    .Resp_Hit(Resp_Hit),
    .Push_Valid(Push_Valid), .Push_Ready(Push_Ready),
    .Push_Msg(Push_Msg),
    .Pop_Valid(Pop_Valid), .Pop_Ready(Pop_Ready),
    .Pop_Data(Pop_Data),
    .Evict(Evict), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string t, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [127:0] fmsg(input logic [23:0] a);
    logic [88:0] m;
    m = {1'b0, a[23:3], 3'b000, 64'h0};
    return 128'(m);
  endfunction

  task automatic issue(input logic w, input logic [23:0] a,
                       input logic [7:0] d);
    chk("req_ready_idle", 128'(Req_Ready), 128'(1));
    Req_Valid = 1'b1;
    Req_Write = w;
    Req_Addr  = a;
    Req_WData = d;
    cyc();
    Req_Valid = 1'b0;
    chk("busy_lookup", 128'(Busy), 128'(1));
  endtask

  task automatic do_hit(input logic w, input logic [23:0] a,
                        input logic [7:0] d, input logic [7:0] exp);
    issue(w, a, d);
    cyc();
    chk("hit_resp_valid", 128'(Resp_Valid), 128'(1));
    chk("hit_resp_data", 128'(Resp_Data), 128'(exp));
    chk("hit_resp_hit", 128'(Resp_Hit), 128'(1));
    chk("hit_no_push", 128'(Push_Valid), 128'(0));
    cyc();
    chk("hit_resp_done", 128'(Resp_Valid), 128'(0));
  endtask

  task automatic do_miss(input logic w, input logic [23:0] a,
                         input logic [7:0] d, input logic dirty,
                         input logic [88:0] wbm,
                         input logic [63:0] line,
                         input logic [7:0] exp);
    issue(w, a, d);
    chk("miss_no_resp", 128'(Resp_Valid), 128'(0));
    cyc();
    chk("miss_push_valid", 128'(Push_Valid), 128'(1));
    if (dirty) begin
      chk("wb_evict", 128'(Evict), 128'(1));
      chk("wb_msg", 128'(Push_Msg), 128'(wbm));
      cyc();
      chk("wb_evict_off", 128'(Evict), 128'(0));
      chk("fill_push_valid", 128'(Push_Valid), 128'(1));
    end else begin
      chk("clean_no_evict", 128'(Evict), 128'(0));
    end
    chk("fill_msg", 128'(Push_Msg), fmsg(a));
    cyc();
    chk("fw_push_idle", 128'(Push_Valid), 128'(0));
    chk("fw_pop_ready", 128'(Pop_Ready), 128'(1));
    Pop_Valid = 1'b1;
    Pop_Data  = {a[23:3], 3'b000, line};
    cyc();
    Pop_Valid = 1'b0;
    chk("commit_pop_ready", 128'(Pop_Ready), 128'(0));
    chk("commit_no_resp", 128'(Resp_Valid), 128'(0));
    cyc();
    chk("miss_resp_valid", 128'(Resp_Valid), 128'(1));
    chk("miss_resp_data", 128'(Resp_Data), 128'(exp));
    chk("miss_resp_hit", 128'(Resp_Hit), 128'(0));
    cyc();
    chk("miss_resp_done", 128'(Resp_Valid), 128'(0));
  endtask

  initial begin
    Reset      = 1'b0;
    Req_Valid  = 1'b0;
    Req_Write  = 1'b0;
    Req_Addr   = '0;
    Req_WData  = '0;
    Push_Ready = 1'b1;
    Pop_Valid  = 1'b0;
    Pop_Data   = '0;
    #2;
    chk("rst_req_ready", 128'(Req_Ready), 128'(1));
    chk("rst_busy", 128'(Busy), 128'(0));
    chk("rst_resp_valid", 128'(Resp_Valid), 128'(0));
    chk("rst_resp_data", 128'(Resp_Data), 128'(0));
    chk("rst_resp_hit", 128'(Resp_Hit), 128'(0));
    chk("rst_push_valid", 128'(Push_Valid), 128'(0));
    chk("rst_push_msg", 128'(Push_Msg), 128'(0));
    chk("rst_pop_ready", 128'(Pop_Ready), 128'(0));
    chk("rst_evict", 128'(Evict), 128'(0));
    @(negedge CLK);
    Reset = 1'b1;
    cyc();

    do_miss(0, 24'h000123, 8'h00, 0, '0,
            64'h1122334455667788, 8'h55);
    do_hit(0, 24'h000123, 8'h00, 8'h55);
    do_hit(1, 24'h000125, 8'hAB, 8'hAB);
    do_hit(0, 24'h000125, 8'h00, 8'hAB);

    do_miss(0, 24'h000060, 8'h00, 0, '0,
            64'hA0A1A2A3A4A5A6A7, 8'hA7);
    do_miss(0, 24'h0000A0, 8'h00, 0, '0,
            64'hB0B1B2B3B4B5B6B7, 8'hB7);
    do_miss(0, 24'h0000E0, 8'h00, 0, '0,
            64'hC0C1C2C3C4C5C6C7, 8'hC7);
    do_miss(0, 24'h000160, 8'h00, 0, '0,
            64'hD0D1D2D3D4D5D6D7, 8'hD7);
    do_hit(0, 24'h0000A0, 8'h00, 8'hB7);
    do_hit(0, 24'h0000E0, 8'h00, 8'hC7);

    do_hit(1, 24'h000125, 8'hAB, 8'hAB);
    do_hit(1, 24'h000161, 8'h11, 8'h11);
    do_hit(1, 24'h0000A2, 8'h22, 8'h22);
    do_hit(1, 24'h0000E3, 8'h33, 8'h33);
    do_miss(0, 24'h0001A0, 8'h00, 1,
            {1'b1, 24'h000120, 64'h1122AB4455667788},
            64'hE0E1E2E3E4E5E6E7, 8'hE7);
    do_hit(1, 24'h0001A0, 8'h44, 8'h44);
    do_miss(0, 24'h0001E0, 8'h00, 1,
            {1'b1, 24'h000160, 64'hD0D1D2D3D4D511D7},
            64'hF0F1F2F3F4F5F6F7, 8'hF7);

    Push_Ready = 1'b0;
    issue(0, 24'h000123, 8'h00);
    cyc();
    for (int i = 0; i < 6; i++) begin
      chk("bp_push_valid", 128'(Push_Valid), 128'(1));
      chk("bp_push_msg", 128'(Push_Msg), fmsg(24'h000120));
      if (i == 5) Push_Ready = 1'b1;
      cyc();
    end
    chk("bp_fw_push_idle", 128'(Push_Valid), 128'(0));
    chk("bp_fw_pop_ready", 128'(Pop_Ready), 128'(1));
    Pop_Valid = 1'b1;
    Pop_Data  = {24'h000200, 64'h0102030405060708};
    cyc();
    chk("badpop_still_wait", 128'(Pop_Ready), 128'(1));
    chk("badpop_no_resp", 128'(Resp_Valid), 128'(0));
    Pop_Data = {24'h000120, 64'h1122334455667788};
    cyc();
    Pop_Valid = 1'b0;
    chk("goodpop_commit", 128'(Pop_Ready), 128'(0));
    cyc();
    chk("bp_resp_valid", 128'(Resp_Valid), 128'(1));
    chk("bp_resp_data", 128'(Resp_Data), 128'(8'h55));
    chk("bp_resp_hit", 128'(Resp_Hit), 128'(0));
    cyc();

    Push_Ready = 1'b0;
    issue(0, 24'h0002A0, 8'h00);
    cyc();
    chk("fr_push_pending", 128'(Push_Valid), 128'(1));
    #2;
    Reset = 1'b0;
    #1;
    chk("fr_rst_push_drop", 128'(Push_Valid), 128'(0));
    chk("fr_rst_busy", 128'(Busy), 128'(0));
    chk("fr_rst_req_ready", 128'(Req_Ready), 128'(1));
    @(negedge CLK);
    Reset = 1'b1;
    Push_Ready = 1'b1;
    cyc();

    issue(0, 24'h0002A0, 8'h00);
    cyc();
    cyc();
    chk("fw_busy", 128'(Busy), 128'(1));
    chk("fw_wait", 128'(Pop_Ready), 128'(1));
    #2;
    Reset = 1'b0;
    #1;
    chk("fw_rst_push", 128'(Push_Valid), 128'(0));
    chk("fw_rst_resp", 128'(Resp_Valid), 128'(0));
    chk("fw_rst_busy", 128'(Busy), 128'(0));
    chk("fw_rst_req_ready", 128'(Req_Ready), 128'(1));
    chk("fw_rst_pop_ready", 128'(Pop_Ready), 128'(0));
    @(negedge CLK);
    Reset = 1'b1;
    cyc();
    chk("post_rst_resp", 128'(Resp_Valid), 128'(0));

    do_miss(0, 24'h000123, 8'h00, 0, '0,
            64'h1122334455667788, 8'h55);
    do_miss(0, 24'h0000A0, 8'h00, 0, '0,
            64'hB0B1B2B3B4B5B6B7, 8'hB7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
